rackctl_txctl_sm_v1: RTL and testbench

RACKCTL_TXCTL_SM_V1 -- requirements
Module: rackctl_txctl_sm_v1

---
 rtl/rackctl_txctl_sm_v1_if.sv | 21 ++
 rtl/rackctl_txctl_sm_v1.sv | 150 +++++++++++++++
 tb/tb_rackctl_txctl_sm_v1.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rackctl_txctl_sm_v1_if.sv
// Transaction-side handshake bundle for the rack control transmitter.
// The master issues requests and the slave (controller) returns completions.
interface rackctl_txctl_sm_v1_if;
    logic        txn_valid_i;
    logic        txn_ready_o;
    logic [23:0] txn_addr_i;
    logic [31:0] txn_data_i;
    logic [31:0] txn_resp_o;
    logic        txn_done_o;
    logic        txn_err_o;

    modport master (
        output txn_valid_i, txn_addr_i, txn_data_i,
        input  txn_ready_o, txn_resp_o, txn_done_o, txn_err_o
    );

    modport slave (
        input  txn_valid_i, txn_addr_i, txn_data_i,
        output txn_ready_o, txn_resp_o, txn_done_o, txn_err_o
    );
endinterface

// File: rtl/rackctl_txctl_sm_v1.sv
// Single-wire rack control transmitter: serialises a request onto the shared
// line, releases it, then waits for the responder start bit and optional read data.
module rackctl_txctl_sm_v1 #(
    parameter logic INV            = 1'b0,
    parameter int   GUARD_CYCLES   = 160,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic                        rxclk_i,
    input  logic                        rst_i,
    rackctl_txctl_sm_v1_if.slave        txn,
    output logic                        rackctl_o,
    output logic                        rackctl_t_o,
    input  logic                        rackctl_i
);
    localparam int CNT_BIG = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX = (CNT_BIG > 64) ? CNT_BIG : 64;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST      = CW'(28);
    localparam logic [CW-1:0] WR_LAST      = CW'(60);
    localparam logic [CW-1:0] RESP_LAST    = CW'(31);

    typedef enum logic [2:0] {
        S_RESET, S_GUARD, S_IDLE, S_SEND, S_WAIT_START, S_RESPONSE, S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [60:0]   r_shift, w_shift_next;
    logic          r_is_read, w_is_read_next;
    logic [1:0]    r_ones, w_ones_next;
    logic          r_rack;
    logic [31:0]   r_rdata, w_rdata_next;
    logic [31:0]   r_resp, w_resp_next;
    logic          r_err, w_err_next;
    logic          r_line_o, w_line_o_next;
    logic          r_line_t, w_line_t_next;
    logic          w_start;
    logic          w_cnt_run;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_is_read_next = r_is_read;
        w_ones_next    = r_ones;
        w_rdata_next   = r_rdata;
        w_resp_next    = r_resp;
        w_err_next     = 1'b0;
        w_line_o_next  = 1'b1;
        w_line_t_next  = 1'b1;
        w_start        = 1'b0;

        case (r_state)
            S_RESET: w_state_next = S_GUARD;
            S_GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_next  = S_IDLE;
                    w_line_t_next = 1'b0;
                end
            end
            S_IDLE: begin
                w_line_t_next = 1'b0;
                if (txn.txn_valid_i) begin
                    // First preamble bit goes out immediately; the rest is pre-shifted.
                    w_state_next   = S_SEND;
                    w_shift_next   = {4'b0101, txn.txn_addr_i, txn.txn_data_i, 1'b0};
                    w_is_read_next = txn.txn_addr_i[23];
                end
            end
            S_SEND: begin
                if (r_cnt == (r_is_read ? RD_LAST : WR_LAST)) begin
                    w_state_next = S_WAIT_START;
                    w_ones_next  = 2'd0;
                end else begin
                    w_line_t_next = 1'b0;
                    w_line_o_next = r_shift[60];
                    w_shift_next  = {r_shift[59:0], 1'b0};
                end
            end
            S_WAIT_START: begin
                w_start     = !r_rack && (r_ones == 2'd2);
                w_ones_next = !r_rack ? 2'd0 : ((r_ones == 2'd2) ? 2'd2 : r_ones + 2'd1);
                // Start bit wins over a coincident timeout.
                if (w_start) begin
                    if (r_is_read) begin
                        w_state_next = S_RESPONSE;
                    end else begin
                        w_state_next = S_DONE;
                        w_resp_next  = 32'h0;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_next = S_DONE;
                    w_resp_next  = 32'hFFFF_FFFF;
                    w_err_next   = 1'b1;
                end
            end
            S_RESPONSE: begin
                w_rdata_next = {r_rdata[30:0], r_rack};
                if (r_cnt == RESP_LAST) begin
                    w_state_next = S_DONE;
                    w_resp_next  = {r_rdata[30:0], r_rack};
                end
            end
            S_DONE:  w_state_next = S_GUARD;
            default: w_state_next = S_RESET;
        endcase

        // Only the timed states count, and every state entry restarts the count.
        w_cnt_run  = (r_state == S_GUARD) || (r_state == S_SEND) ||
                     (r_state == S_WAIT_START) || (r_state == S_RESPONSE);
        w_cnt_next = (w_cnt_run && (w_state_next == r_state)) ? r_cnt + CW'(1) : '0;
    end

    always_ff @(posedge rxclk_i) begin
        if (rst_i) begin
            r_state   <= S_RESET;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_is_read <= 1'b0;
            r_ones    <= 2'd0;
            r_rack    <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_err     <= 1'b0;
            r_line_o  <= INV;
            r_line_t  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_is_read <= w_is_read_next;
            r_ones    <= w_ones_next;
            r_rack    <= rackctl_i ^ INV;
            r_rdata   <= w_rdata_next;
            r_resp    <= w_resp_next;
            r_err     <= w_err_next;
            r_line_o  <= w_line_o_next ^ INV;
            r_line_t  <= w_line_t_next;
        end
    end

    assign txn.txn_ready_o = (r_state == S_IDLE);
    assign txn.txn_done_o  = (r_state == S_DONE);
    assign txn.txn_err_o   = r_err;
    assign txn.txn_resp_o  = r_resp;
    assign rackctl_o       = r_line_o;
    assign rackctl_t_o     = r_line_t;
endmodule

// File: tb/tb_rackctl_txctl_sm_v1.sv
// Directed bench: a plain and an inverted-polarity controller run side by side
// against the same transactions and a simple line responder.
module tb_rackctl_txctl_sm_v1;
    localparam int G = 8;
    localparam int T = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rack_i;
    logic o0, t0, o1, t1;
    int   n_vec = 0;
    int   n_err = 0;

    rackctl_txctl_sm_v1_if bus0();
    rackctl_txctl_sm_v1_if bus1();

    rackctl_txctl_sm_v1 #(.INV(1'b0), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut0 (
        .rxclk_i(clk), .rst_i(rst), .txn(bus0),
        .rackctl_o(o0), .rackctl_t_o(t0), .rackctl_i(rack_i)
    );

    rackctl_txctl_sm_v1 #(.INV(1'b1), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut1 (
        .rxclk_i(clk), .rst_i(rst), .txn(bus1),
        .rackctl_o(o1), .rackctl_t_o(t1), .rackctl_i(~rack_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [23:0] a, input logic [31:0] d);
        bus0.txn_valid_i = v; bus0.txn_addr_i = a; bus0.txn_data_i = d;
        bus1.txn_valid_i = v; bus1.txn_addr_i = a; bus1.txn_data_i = d;
    endtask

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!(bus0.txn_ready_o && bus1.txn_ready_o) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "/ready"}, 64'({bus1.txn_ready_o, bus0.txn_ready_o}), 64'(2'b11));
    endtask

    // Call at the negedge where the RESET state is visible and rst_i is low.
    task automatic guard_count(input string tag);
        int   c;
        logic saw_done;
        c = 0;
        saw_done = 1'b0;
        while ((t0 || t1) && c < 1000) begin
            saw_done = saw_done | bus0.txn_done_o | bus1.txn_done_o;
            c++;
            @(negedge clk);
        end
        chk({tag, "/guard_len"}, 64'(c), 64'(G + 1));
        chk({tag, "/idle_pins"},
            64'({t1, t0, o1, o0, bus1.txn_ready_o, bus0.txn_ready_o}), 64'(6'b000111));
        chk({tag, "/no_done"}, 64'(saw_done), 64'(1'b0));
    endtask

    // mode 0: responder 1,1,1,0[,data]; 1: no responder; 2: early 0 then 1,1,0[,data]
    task automatic do_txn(input string tag, input logic [23:0] addr, input logic [31:0] data,
                          input int mode, input logic [31:0] rdata);
        logic        rd, exp_err, drv_bad;
        int          nb, w;
        logic [63:0] cap0, cap1, expv;
        logic [31:0] exp_resp;
        logic        q[$];
        rd       = addr[23];
        nb       = rd ? 29 : 61;
        expv     = rd ? {35'd0, 5'b10101, addr} : {3'd0, 5'b10101, addr, data};
        exp_err  = (mode == 1);
        exp_resp = exp_err ? 32'hFFFF_FFFF : (rd ? rdata : 32'h0);

        wait_ready(tag);
        drive_req(1'b1, addr, data);
        cap0 = '0; cap1 = '0; drv_bad = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == 0) drive_req(1'b0, 24'h0, 32'h0);
            cap0    = {cap0[62:0], o0};
            cap1    = {cap1[62:0], ~o1};
            drv_bad = drv_bad | t0 | t1;
        end
        chk({tag, "/bits"}, cap0, expv);
        chk({tag, "/bits_inv"}, cap1, expv);
        chk({tag, "/driven"}, 64'(drv_bad), 64'(1'b0));
        @(negedge clk);
        chk({tag, "/release"}, 64'({t1, t0}), 64'(2'b11));

        if (mode == 0) begin
            q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
        end else if (mode == 2) begin
            q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
        end
        if (mode != 1 && rd) begin
            for (int i = 31; i >= 0; i--) q.push_back(rdata[i]);
        end
        foreach (q[i]) begin
            rack_i = q[i];
            @(negedge clk);
        end
        rack_i = 1'b1;

        w = 0;
        while (!bus0.txn_done_o && w < T + 20) begin
            @(negedge clk);
            w++;
        end
        if (mode == 1) chk({tag, "/timeout_cycles"}, 64'(w), 64'(T));
        chk({tag, "/done"}, 64'({bus1.txn_done_o, bus0.txn_done_o}), 64'(2'b11));
        chk({tag, "/resp"}, 64'(bus0.txn_resp_o), 64'(exp_resp));
        chk({tag, "/resp_inv"}, 64'(bus1.txn_resp_o), 64'(exp_resp));
        chk({tag, "/err"}, 64'({bus1.txn_err_o, bus0.txn_err_o}), 64'({exp_err, exp_err}));
        @(negedge clk);
        chk({tag, "/done_pulse"},
            64'({bus1.txn_done_o, bus0.txn_done_o, t1, t0, bus1.txn_ready_o, bus0.txn_ready_o}),
            64'(6'b001100));
        chk({tag, "/resp_hold"}, 64'(bus0.txn_resp_o), 64'(exp_resp));
    endtask

    initial begin
        rst    = 1'b1;
        rack_i = 1'b1;
        drive_req(1'b0, 24'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/pins",
            64'({t1, t0, o1, o0, bus1.txn_ready_o, bus0.txn_ready_o,
                 bus1.txn_done_o, bus0.txn_done_o, bus1.txn_err_o, bus0.txn_err_o}),
            64'(10'b1110000000));
        chk("reset/resp", 64'({bus1.txn_resp_o, bus0.txn_resp_o}), 64'h0);
        rst = 1'b0;
        guard_count("reset");

        do_txn("wr",        24'h000010, 32'hDEADBEEF, 0, 32'h0);
        do_txn("rd",        24'h800004, 32'h0,        0, 32'h12345678);
        do_txn("rd_to",     24'h800123, 32'h0,        1, 32'h0);
        do_txn("rd_early0", 24'h80ABCD, 32'h0,        2, 32'hA5C30F96);

        // Abort a write while bit 10 is on the line.
        wait_ready("abort");
        drive_req(1'b1, 24'h00BEEF, 32'hCAFEF00D);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) drive_req(1'b0, 24'h0, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort/pins",
            64'({t1, t0, bus1.txn_done_o, bus0.txn_done_o, bus1.txn_ready_o, bus0.txn_ready_o}),
            64'(6'b110000));
        rst = 1'b0;
        guard_count("abort");
        chk("abort/resp_cleared", 64'(bus0.txn_resp_o), 64'h0);

        do_txn("wr2", 24'h123456, 32'h0F0F1234, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
